pcie_event_counter_bank: RTL and testbench

//  Bank of NCH independent event counters for the PCIe transaction layer; one per FIFO/VC channel, counting accepted pushes.

---
 rtl/pcie_cnt_pkg.sv | 15 +
 rtl/pcie_event_counter_bank_if.sv | 28 ++
 rtl/pcie_cnt_channel.sv | 42 ++++
 rtl/pcie_event_counter_bank.sv | 92 +++++++++
 tb/tb_pcie_event_counter_bank.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pcie_cnt_pkg.sv
// Shared state encoding for the PCIe event counter bank.
// Latency: none (constants only).
// Backpressure: none.
package pcie_cnt_pkg;

  // One-hot control state driven by the upstream transaction-layer FSM.
  // Any pattern that is not one of these is held like IDLE.
  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } cnt_state_e;

endpackage

// File: rtl/pcie_event_counter_bank_if.sv
// Control, event and read-port bundle between the transaction layer and the counter bank.
// Latency: none (wires only).
// Backpressure: none; the read port accepts one request every cycle.
interface pcie_event_counter_bank_if #(
  parameter int NCH   = 4,
  parameter int IDX_W = 3,
  parameter int CNT_W = 5
);
  logic [3:0]       state;
  logic [NCH-1:0]   inc;
  logic             req;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cuenta;
  logic             valid;
  logic             idx_err;
  logic [NCH-1:0]   ovf;
  logic             idle;

  modport master (
    output state, inc, req, idx,
    input  cuenta, valid, idx_err, ovf, idle
  );

  modport slave (
    input  state, inc, req, idx,
    output cuenta, valid, idx_err, ovf, idle
  );
endinterface

// File: rtl/pcie_cnt_channel.sv
// One event counter with wrap or saturate behaviour and a sticky overflow flag.
// Latency: count updates on the edge after en/clr/clr_rd.
// Backpressure: none; one event per cycle is always absorbed.
module pcie_cnt_channel #(
  parameter int CNT_W    = 5,
  parameter int SAT_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             clr_rd,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Counter and overflow flag; a clear-on-read that coincides with an event
  // restarts at 1 so the event is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (en) begin
      if (clr_rd) begin
        count <= CNT_W'(1);
      end else if (count == CNT_MAX) begin
        ovf   <= 1'b1;
        count <= (SAT_MODE != 0) ? CNT_MAX : '0;
      end else begin
        count <= count + 1'b1;
      end
    end else if (clr_rd) begin
      count <= '0;
    end
  end

endmodule

// File: rtl/pcie_event_counter_bank.sv
// Bank of per-channel PCIe push counters gated by the one-hot control state, with a registered read port.
// Latency: read result (cuenta/valid/idx_err) one cycle after req; idle one cycle after state/count change.
// Backpressure: none; back-to-back reads return one result per cycle.
module pcie_event_counter_bank
  import pcie_cnt_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int IDX_W    = 3,
  parameter int CNT_W    = 5,
  parameter int SAT_MODE = 0,
  parameter int CLR_RD   = 0
) (
  input logic                     clk,
  input logic                     reset,
  pcie_event_counter_bank_if.slave bus
);

  logic             st_reset;
  logic             st_active;
  logic             idx_ok;
  logic [CNT_W-1:0] cnt [NCH];
  logic [NCH-1:0]   ovf_w;
  logic [CNT_W-1:0] rd_val;
  logic             all_zero;
  logic [CNT_W-1:0] cuenta_q;
  logic             valid_q;
  logic             idx_err_q;
  logic             idle_q;

  // Non-one-hot states match neither compare and so simply hold the counters.
  assign st_reset  = (bus.state == ST_RESET);
  assign st_active = (bus.state == ST_ACTIVE);
  // Widen by one bit so NCH == 2**IDX_W does not alias to zero.
  assign idx_ok    = ({1'b0, bus.idx} < (IDX_W + 1)'(NCH));

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic rd_clr;
    assign rd_clr = (CLR_RD != 0) && bus.req && (bus.idx == IDX_W'(g));

    pcie_cnt_channel #(
      .CNT_W    (CNT_W),
      .SAT_MODE (SAT_MODE)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .clr    (st_reset),
      .en     (st_active && bus.inc[g]),
      .clr_rd (rd_clr),
      .count  (cnt[g]),
      .ovf    (ovf_w[g])
    );
  end

  // Read mux: out-of-range index or a bank being cleared returns zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.idx == IDX_W'(i)) rd_val = cnt[i];
    end
    if (st_reset) rd_val = '0;
  end

  // Zero detect across every channel for the idle indication.
  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cnt[i] != '0) all_zero = 1'b0;
    end
  end

  // Registered read result and idle flag; cuenta holds between requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cuenta_q  <= '0;
      valid_q   <= 1'b0;
      idx_err_q <= 1'b0;
      idle_q    <= 1'b0;
    end else begin
      valid_q   <= bus.req;
      idx_err_q <= bus.req && !idx_ok;
      if (bus.req) cuenta_q <= rd_val;
      idle_q    <= (bus.state == ST_IDLE) && all_zero;
    end
  end

  assign bus.cuenta  = cuenta_q;
  assign bus.valid   = valid_q;
  assign bus.idx_err = idx_err_q;
  assign bus.ovf     = ovf_w;
  assign bus.idle    = idle_q;

endmodule

// File: tb/tb_pcie_event_counter_bank.sv
module tb_pcie_event_counter_bank;

  localparam logic [3:0] S_RST = 4'b0001;
  localparam logic [3:0] S_INI = 4'b0010;
  localparam logic [3:0] S_IDL = 4'b0100;
  localparam logic [3:0] S_ACT = 4'b1000;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Three builds: wrap, saturate, clear-on-read.
  pcie_event_counter_bank_if #(.NCH(4), .IDX_W(3), .CNT_W(5)) if_w ();
  pcie_event_counter_bank_if #(.NCH(4), .IDX_W(3), .CNT_W(5)) if_s ();
  pcie_event_counter_bank_if #(.NCH(4), .IDX_W(3), .CNT_W(5)) if_c ();

  pcie_event_counter_bank #(.NCH(4), .IDX_W(3), .CNT_W(5), .SAT_MODE(0), .CLR_RD(0))
    u_wrap (.clk(clk), .reset(rst), .bus(if_w));
  pcie_event_counter_bank #(.NCH(4), .IDX_W(3), .CNT_W(5), .SAT_MODE(1), .CLR_RD(0))
    u_sat (.clk(clk), .reset(rst), .bus(if_s));
  pcie_event_counter_bank #(.NCH(4), .IDX_W(3), .CNT_W(5), .SAT_MODE(0), .CLR_RD(1))
    u_clr (.clk(clk), .reset(rst), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer counts per build and channel.
  int mode_sat [3] = '{0, 1, 0};
  int mode_clr [3] = '{0, 0, 1};
  int cnt      [3][4];
  int ovfm     [3][4];
  int exp_cuenta [3];
  int exp_valid  [3];
  int exp_err    [3];
  int exp_idle   [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < 4; i++) begin
        cnt[m][i]  = 0;
        ovfm[m][i] = 0;
      end
      exp_cuenta[m] = 0;
      exp_valid[m]  = 0;
      exp_err[m]    = 0;
      exp_idle[m]   = 0;
    end
  endtask

  task automatic model_update(input logic [3:0] st, input logic [3:0] iv, input logic rq, input int ix);
    for (int m = 0; m < 3; m++) begin
      int all0;
      all0 = 1;
      for (int i = 0; i < 4; i++) if (cnt[m][i] != 0) all0 = 0;
      exp_idle[m]  = (st == S_IDL && all0 == 1) ? 1 : 0;
      exp_valid[m] = rq ? 1 : 0;
      exp_err[m]   = (rq && ix >= 4) ? 1 : 0;
      if (rq) exp_cuenta[m] = (ix >= 4 || st == S_RST) ? 0 : cnt[m][ix];
      for (int i = 0; i < 4; i++) begin
        bit rd;
        rd = (mode_clr[m] == 1) && rq && (ix == i);
        if (st == S_RST) begin
          cnt[m][i]  = 0;
          ovfm[m][i] = 0;
        end else if (st == S_ACT && iv[i]) begin
          if (rd) cnt[m][i] = 1;
          else if (cnt[m][i] == 31) begin
            ovfm[m][i] = 1;
            cnt[m][i]  = (mode_sat[m] == 1) ? 31 : 0;
          end else cnt[m][i] = cnt[m][i] + 1;
        end else if (rd) cnt[m][i] = 0;
      end
    end
  endtask

  task automatic get_out(input int m, output logic [4:0] c, output logic v, output logic e,
                         output logic [3:0] o, output logic id);
    case (m)
      0:       begin c = if_w.cuenta; v = if_w.valid; e = if_w.idx_err; o = if_w.ovf; id = if_w.idle; end
      1:       begin c = if_s.cuenta; v = if_s.valid; e = if_s.idx_err; o = if_s.ovf; id = if_s.idle; end
      default: begin c = if_c.cuenta; v = if_c.valid; e = if_c.idx_err; o = if_c.ovf; id = if_c.idle; end
    endcase
  endtask

  task automatic check_all(input string where);
    for (int m = 0; m < 3; m++) begin
      logic [4:0] c;
      logic v, e, id;
      logic [3:0] o, eo;
      get_out(m, c, v, e, o, id);
      for (int i = 0; i < 4; i++) eo[i] = (ovfm[m][i] != 0);
      chk($sformatf("%s m%0d valid", where, m), 32'(v), 32'(exp_valid[m]));
      chk($sformatf("%s m%0d idx_err", where, m), 32'(e), 32'(exp_err[m]));
      chk($sformatf("%s m%0d cuenta", where, m), 32'(c), 32'(exp_cuenta[m]));
      chk($sformatf("%s m%0d ovf", where, m), 32'(o), 32'(eo));
      chk($sformatf("%s m%0d idle", where, m), 32'(id), 32'(exp_idle[m]));
    end
  endtask

  task automatic drive(input logic [3:0] st, input logic [3:0] iv, input logic rq, input logic [2:0] ix);
    if_w.state = st; if_w.inc = iv; if_w.req = rq; if_w.idx = ix;
    if_s.state = st; if_s.inc = iv; if_s.req = rq; if_s.idx = ix;
    if_c.state = st; if_c.inc = iv; if_c.req = rq; if_c.idx = ix;
  endtask

  task automatic step(input string where, input logic [3:0] st, input logic [3:0] iv,
                      input logic rq, input logic [2:0] ix);
    @(negedge clk);
    drive(st, iv, rq, ix);
    model_update(st, iv, rq, int'(ix));
    @(posedge clk);
    #1;
    check_all(where);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(S_RST, 4'b0000, 1'b0, 3'd0);
    model_reset();

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // ACTIVE with no events; every channel reads zero.
    for (int i = 0; i < 4; i++) step("t1 read", S_ACT, 4'b0000, 1'b1, 3'(i));
    step("t1 noreq", S_ACT, 4'b0000, 1'b0, 3'd0);
    chk("t1 valid drops", 32'(if_w.valid), 32'd0);

    // Four events on channel 0, two on channel 2.
    step("t2 ev", S_ACT, 4'b0101, 1'b0, 3'd0);
    step("t2 ev", S_ACT, 4'b0101, 1'b0, 3'd0);
    step("t2 ev", S_ACT, 4'b0001, 1'b0, 3'd0);
    step("t2 ev", S_ACT, 4'b0001, 1'b0, 3'd0);
    step("t2 rd0", S_ACT, 4'b0000, 1'b1, 3'd0);
    chk("t2 cuenta ch0", 32'(if_w.cuenta), 32'd4);
    step("t2 rd2", S_ACT, 4'b0000, 1'b1, 3'd2);
    chk("t2 cuenta ch2", 32'(if_w.cuenta), 32'd2);
    step("t2 rd1", S_ACT, 4'b0000, 1'b1, 3'd1);
    chk("t2 cuenta ch1", 32'(if_w.cuenta), 32'd0);

    // 33 events on channel 1: wrap gives 1, saturate gives 31.
    for (int k = 0; k < 33; k++) step("t3 ev", S_ACT, 4'b0010, 1'b0, 3'd0);
    step("t3 rd1", S_IDL, 4'b0000, 1'b1, 3'd1);
    chk("t3 wrap cuenta", 32'(if_w.cuenta), 32'd1);
    chk("t3 wrap ovf1", 32'(if_w.ovf[1]), 32'd1);
    chk("t3 sat cuenta", 32'(if_s.cuenta), 32'd31);
    chk("t3 sat ovf1", 32'(if_s.ovf[1]), 32'd1);

    // Clear-on-read racing an event on channel 3.
    for (int k = 0; k < 7; k++) step("t4 ev", S_ACT, 4'b1000, 1'b0, 3'd0);
    step("t4 rd3", S_ACT, 4'b1000, 1'b1, 3'd3);
    chk("t4 clr first read", 32'(if_c.cuenta), 32'd7);
    step("t4 rd3b", S_ACT, 4'b0000, 1'b1, 3'd3);
    chk("t4 clr second read", 32'(if_c.cuenta), 32'd1);

    // Out-of-range index, synchronous clear, then idle.
    step("t5 rd5", S_ACT, 4'b0000, 1'b1, 3'd5);
    chk("t5 idx_err", 32'(if_w.idx_err), 32'd1);
    chk("t5 cuenta", 32'(if_w.cuenta), 32'd0);
    step("t5 clear", S_RST, 4'b1111, 1'b0, 3'd0);
    chk("t5 ovf cleared wrap", 32'(if_w.ovf), 32'd0);
    chk("t5 ovf cleared sat", 32'(if_s.ovf), 32'd0);
    step("t5 idle", S_IDL, 4'b0000, 1'b0, 3'd0);
    chk("t5 idle high", 32'(if_w.idle), 32'd1);

    // Asynchronous reset between edges.
    for (int k = 0; k < 3; k++) step("t6 ev", S_ACT, 4'b1111, 1'b0, 3'd0);
    step("t6 rd0", S_ACT, 4'b0000, 1'b1, 3'd0);
    chk("t6 pre-reset cuenta", 32'(if_w.cuenta), 32'd3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6 async cuenta", 32'(if_w.cuenta), 32'd0);
    chk("t6 async valid", 32'(if_w.valid), 32'd0);
    check_all("t6 async");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step("t6 ev", S_ACT, 4'b0001, 1'b0, 3'd0);
    step("t6 ev", S_ACT, 4'b0001, 1'b0, 3'd0);
    step("t6 rd0", S_ACT, 4'b0000, 1'b1, 3'd0);
    chk("t6 resume cuenta", 32'(if_w.cuenta), 32'd2);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      int r;
      logic [3:0] st;
      r = int'($urandom_range(0, 99));
      if (r < 2)       st = S_RST;
      else if (r < 10) st = S_INI;
      else if (r < 20) st = S_IDL;
      else if (r < 25) st = (r % 2 == 0) ? 4'b0000 : 4'b1010;
      else             st = S_ACT;
      step("rand", st, 4'($urandom), 1'($urandom), 3'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
